// File: rtl/mult_cell_arbiter.sv
// -----------------------------------------------------------------------------
// mult_cell_arbiter
//
// Shares one pipelined 32-bit multiplier cell among NUM_REQ requesters. Each
// cycle at most one pending request is granted, and its operands are muxed
// straight onto the cell inputs. Every accepted operation carries an ID tag
// down a shift pipeline that matches the cell latency. When the tag reaches
// the end of that pipeline, the cell product is returned to the requester
// that issued the operation. Each requester may have only one operation in
// flight. It may be granted again in the same cycle that its previous
// operation completes, so a single requester can still issue one operation
// per cycle.
//
// Build option:
//   MULT_CELL_ARBITER_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                                    undefined -> round-robin starting at rr_ptr
//
// Parameters:
//   NUM_REQ      number of requesters (2..8)
//   ID_W         requester ID width (>= clog2(NUM_REQ))
//   MUL_LATENCY  cycles from mul_src* to a valid mul_result (1..4)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req_valid    per-requester operation request
//   req_ready    per-requester grant (one-hot or zero); accept = valid & ready
//   req_src1/2   flattened operands, requester i at bits [32i+31:32i]
//   mul_src1/2   operands to the multiplier cell (zero when nothing is granted)
//   mul_result   product from the multiplier cell
//   rsp_valid    one-hot, one-cycle completion pulse
//   rsp_id       ID of the completing requester
//   rsp_result   product, meaningful only while rsp_valid is non-zero
//   busy         high while any operation is in flight
// -----------------------------------------------------------------------------
module mult_cell_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int MUL_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_src1,
  input  logic [NUM_REQ*32-1:0]   req_src2,
  output logic [31:0]             mul_src1,
  output logic [31:0]             mul_src2,
  input  logic [31:0]             mul_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    busy
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mult_cell_arbiter: NUM_REQ must be in 2..8");
  end
  if (ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("mult_cell_arbiter: ID_W too narrow for NUM_REQ");
  end
  if (MUL_LATENCY < 1 || MUL_LATENCY > 4) begin : g_bad_latency
    $error("mult_cell_arbiter: MUL_LATENCY must be in 1..4");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0]     outstanding;               // one op in flight per requester
  logic [MUL_LATENCY-1:0] tag_valid;                 // tag pipeline occupancy
  logic [ID_W-1:0]        tag_id [MUL_LATENCY];      // tag pipeline owner IDs
  logic [ID_W-1:0]        rr_ptr;                    // first index searched

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic                   tag_done;
  logic [ID_W-1:0]        done_id;
  logic [NUM_REQ-1:0]     completing;
  logic [NUM_REQ-1:0]     eligible;
  logic                   grant_any;
  logic [ID_W-1:0]        grant_id;
  logic [NUM_REQ-1:0]     grant_mask;

  // ---------------------------------------------------------------------------
  // Completion. The tag leaving the last pipeline stage lines up with the
  // cell's product for that operation. While reset is asserted, the pipeline
  // contents are being discarded, so nothing is reported.
  // ---------------------------------------------------------------------------
  assign tag_done   = tag_valid[MUL_LATENCY-1] & ~reset;
  assign done_id    = tag_id[MUL_LATENCY-1];
  assign completing = tag_done ? (NUM_REQ'(1) << done_id) : '0;

  assign rsp_valid  = completing;
  assign rsp_id     = tag_done ? done_id : '0;
  assign rsp_result = tag_done ? mul_result : '0;
  assign busy       = |outstanding;

  // ---------------------------------------------------------------------------
  // Eligibility. A requester whose operation completes this cycle is free
  // again immediately, so it can be re-granted without a bubble.
  // ---------------------------------------------------------------------------
  assign eligible = reset ? '0 : (req_valid & (~outstanding | completing));

  // ---------------------------------------------------------------------------
  // Arbitration: the first eligible index at or after rr_ptr, wrapping modulo
  // NUM_REQ. In fixed-priority builds rr_ptr is tied to zero, so the lowest
  // index always wins.
  // ---------------------------------------------------------------------------
  always_comb begin : arb
    int idx;
    // NOTE: every variable assigned in a combinational block gets a default
    // first; otherwise paths that skip the assignment infer a latch.
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign grant_mask = grant_any ? (NUM_REQ'(1) << grant_id) : '0;
  assign req_ready  = grant_mask;

  // The operands of the granted requester go to the cell in the same cycle.
  // With no grant, the cell sees zeros.
  assign mul_src1 = grant_any ? req_src1[int'(grant_id)*32 +: 32] : '0;
  assign mul_src2 = grant_any ? req_src2[int'(grant_id)*32 +: 32] : '0;

  // ---------------------------------------------------------------------------
  // Control state: outstanding flags and tag-pipeline valid bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      tag_valid   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // here samples the pre-edge values and the order of statements is
      // irrelevant.
      // A same-cycle completion and re-grant of one ID leaves its flag set.
      outstanding  <= (outstanding & ~completing) | grant_mask;
      tag_valid[0] <= grant_any;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag-pipeline IDs
  // ---------------------------------------------------------------------------
  // NOTE: the ID stages hold data only and are not reset. Their matching
  // valid bits are reset, so a stale ID is never acted upon.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      tag_id[k] <= tag_id[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer
  // ---------------------------------------------------------------------------
`ifdef MULT_CELL_ARBITER_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [ID_W-1:0] rr_next;

  // After a grant, the search restarts one past the winner, so the winner is
  // checked last next time.
  assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= rr_next;
    end
  end
`endif

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_cell_arbiter
//
// Self-checking bench for mult_cell_arbiter. Instance "a" uses
// MUL_LATENCY=1 and is driven from a table of per-cycle vectors. Instance "b"
// uses MUL_LATENCY=3 and is driven by a hand-written sequence covering
// in-flight blocking, completion re-grant and reset mid-operation. Each
// instance has a behavioural multiplier cell whose latency matches it.
// -----------------------------------------------------------------------------
module tb_mult_cell_arbiter;

  logic clk;

  // Instance a: latency 1
  logic         a_reset;
  logic [3:0]   a_valid, a_ready, a_rsp_valid;
  logic [127:0] a_src1, a_src2;
  logic [31:0]  a_mul_src1, a_mul_src2, a_mul_result, a_rsp_result;
  logic [1:0]   a_rsp_id;
  logic         a_busy;

  // Instance b: latency 3
  logic         b_reset;
  logic [3:0]   b_valid, b_ready, b_rsp_valid;
  logic [127:0] b_src1, b_src2;
  logic [31:0]  b_mul_src1, b_mul_src2, b_mul_result, b_rsp_result;
  logic [1:0]   b_rsp_id;
  logic         b_busy;
  logic [31:0]  b_p0, b_p1;

  int checks = 0;
  int errors = 0;

  mult_cell_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LATENCY(1)) u_a (
    .clk        (clk),
    .reset      (a_reset),
    .req_valid  (a_valid),
    .req_ready  (a_ready),
    .req_src1   (a_src1),
    .req_src2   (a_src2),
    .mul_src1   (a_mul_src1),
    .mul_src2   (a_mul_src2),
    .mul_result (a_mul_result),
    .rsp_valid  (a_rsp_valid),
    .rsp_id     (a_rsp_id),
    .rsp_result (a_rsp_result),
    .busy       (a_busy)
  );

  mult_cell_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LATENCY(3)) u_b (
    .clk        (clk),
    .reset      (b_reset),
    .req_valid  (b_valid),
    .req_ready  (b_ready),
    .req_src1   (b_src1),
    .req_src2   (b_src2),
    .mul_src1   (b_mul_src1),
    .mul_src2   (b_mul_src2),
    .mul_result (b_mul_result),
    .rsp_valid  (b_rsp_valid),
    .rsp_id     (b_rsp_id),
    .rsp_result (b_rsp_result),
    .busy       (b_busy)
  );

  // Behavioural multiplier cells: 32-bit low word of the product
  always @(posedge clk) a_mul_result <= a_mul_src1 * a_mul_src2;

  always @(posedge clk) begin
    b_p0         <= b_mul_src1 * b_mul_src2;
    b_p1         <= b_p0;
    b_mul_result <= b_p1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Vector table for instance a
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         rst;
    logic [3:0]   valid;
    logic [127:0] src1;
    logic [127:0] src2;
    logic [3:0]   exp_ready;
    logic [3:0]   exp_rsp;
    logic [1:0]   exp_id;
    logic [31:0]  exp_res;
    logic         exp_busy;
    logic [31:0]  exp_msrc1;
  } vec_t;

  vec_t         vecs[$];
  vec_t         v;
  logic [127:0] cur_src1, cur_src2;

  task automatic set_src(input int i, input logic [31:0] s1, input logic [31:0] s2);
    cur_src1[i*32 +: 32] = s1;
    cur_src2[i*32 +: 32] = s2;
  endtask

  task automatic add(input logic rst, input logic [3:0] valid,
                     input logic [3:0] ready, input logic [3:0] rsp,
                     input logic [1:0] id, input logic [31:0] res,
                     input logic busy, input logic [31:0] msrc1);
    vec_t r;
    r.rst       = rst;
    r.valid     = valid;
    r.src1      = cur_src1;
    r.src2      = cur_src2;
    r.exp_ready = ready;
    r.exp_rsp   = rsp;
    r.exp_id    = id;
    r.exp_res   = res;
    r.exp_busy  = busy;
    r.exp_msrc1 = msrc1;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Instance b: one cycle with the given reset/valid, then settle.
  task automatic b_step(input logic rst, input logic [3:0] valid);
    @(posedge clk);
    #2;
    b_reset = rst;
    b_valid = valid;
    #2;
  endtask

  initial begin
    a_reset = 1'b1;  a_valid = '0;  a_src1 = '0;  a_src2 = '0;
    b_reset = 1'b1;  b_valid = '0;  b_src1 = '0;  b_src2 = '0;
    cur_src1 = '0;
    cur_src2 = '0;

    // ---------------- table fill (instance a, latency 1) ----------------
    //   rst valid   ready    rsp     id  result        busy msrc1
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);  // 0 reset
    add(1, 4'b1111, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);  // 1 no grant in reset
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);  // 2
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);  // 3
    // Single operation
    set_src(0, 32'h0000_1234, 32'h0000_0010);
    add(0, 4'b0001, 4'b0001, 4'b0000, 0, 32'h0,        0, 32'h1234); // 4 accept
    add(0, 4'b0000, 4'b0000, 4'b0001, 0, 32'h0001_2340, 1, 32'h0);   // 5 response
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);    // 6
    // All four requesters from reset release
    for (int i = 0; i < 4; i++) set_src(i, 32'(i + 2), 32'h1000_0001);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);    // 7 reset
`ifdef MULT_CELL_ARBITER_FIXED_PRIO_EN
    add(0, 4'b1111, 4'b0001, 4'b0000, 0, 32'h0,         0, 32'h2);   // 8
    for (int i = 0; i < 5; i++)
      add(0, 4'b1111, 4'b0001, 4'b0001, 0, 32'h2000_0002, 1, 32'h2); // 9..13
    add(0, 4'b0000, 4'b0000, 4'b0001, 0, 32'h2000_0002, 1, 32'h0);   // 14
`else
    add(0, 4'b1111, 4'b0001, 4'b0000, 0, 32'h0,         0, 32'h2);   // 8
    add(0, 4'b1111, 4'b0010, 4'b0001, 0, 32'h2000_0002, 1, 32'h3);   // 9
    add(0, 4'b1111, 4'b0100, 4'b0010, 1, 32'h3000_0003, 1, 32'h4);   // 10
    add(0, 4'b1111, 4'b1000, 4'b0100, 2, 32'h4000_0004, 1, 32'h5);   // 11
    add(0, 4'b1111, 4'b0001, 4'b1000, 3, 32'h5000_0005, 1, 32'h2);   // 12
    add(0, 4'b1111, 4'b0010, 4'b0001, 0, 32'h2000_0002, 1, 32'h3);   // 13
    add(0, 4'b0000, 4'b0000, 4'b0010, 1, 32'h3000_0003, 1, 32'h0);   // 14
`endif
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);    // 15
    // Back-to-back single requester; also covers the wrap/truncation cases
    set_src(1, 32'h7, 32'h9);
    add(0, 4'b0010, 4'b0010, 4'b0000, 0, 32'h0,        0, 32'h7);            // 16
    set_src(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 32'h3F,       1, 32'hFFFF_FFFF);    // 17
    set_src(1, 32'h0001_0000, 32'h0001_0000);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 32'h1,        1, 32'h0001_0000);    // 18
    set_src(1, 32'h1000, 32'h3);
    add(0, 4'b0010, 4'b0010, 4'b0010, 1, 32'h0,        1, 32'h1000);         // 19
    add(0, 4'b0000, 4'b0000, 4'b0010, 1, 32'h3000,     1, 32'h0);            // 20
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);            // 21
    // Contention between req0 and req3 (rr_ptr is 2 here in round-robin mode)
    set_src(0, 32'h11, 32'h2);
    set_src(3, 32'h100, 32'h3);
`ifdef MULT_CELL_ARBITER_FIXED_PRIO_EN
    add(0, 4'b1001, 4'b0001, 4'b0000, 0, 32'h0,        0, 32'h11);  // 22
    add(0, 4'b1001, 4'b0001, 4'b0001, 0, 32'h22,       1, 32'h11);  // 23
    add(0, 4'b1001, 4'b0001, 4'b0001, 0, 32'h22,       1, 32'h11);  // 24
    add(0, 4'b0000, 4'b0000, 4'b0001, 0, 32'h22,       1, 32'h0);   // 25
`else
    add(0, 4'b1001, 4'b1000, 4'b0000, 0, 32'h0,        0, 32'h100); // 22
    add(0, 4'b1001, 4'b0001, 4'b1000, 3, 32'h300,      1, 32'h11);  // 23
    add(0, 4'b1001, 4'b1000, 4'b0001, 0, 32'h22,       1, 32'h100); // 24
    add(0, 4'b0000, 4'b0000, 4'b1000, 3, 32'h300,      1, 32'h0);   // 25
`endif
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0,        0, 32'h0);   // 26

    // ---------------- apply table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk);
      #2;
      a_reset = v.rst;
      a_valid = v.valid;
      a_src1  = v.src1;
      a_src2  = v.src2;
      #2;
      check($sformatf("a_row%0d_ready", i), 32'(a_ready), 32'(v.exp_ready));
      check($sformatf("a_row%0d_rsp_valid", i), 32'(a_rsp_valid), 32'(v.exp_rsp));
      check($sformatf("a_row%0d_busy", i), 32'(a_busy), 32'(v.exp_busy));
      check($sformatf("a_row%0d_mul_src1", i), a_mul_src1, v.exp_msrc1);
      if (v.exp_rsp != 4'b0000 || v.rst) begin
        check($sformatf("a_row%0d_rsp_id", i), 32'(a_rsp_id), 32'(v.exp_id));
      end
      if (v.exp_rsp != 4'b0000) begin
        check($sformatf("a_row%0d_rsp_result", i), a_rsp_result, v.exp_res);
      end
    end
    a_valid = '0;

    // ---------------- instance b: latency 3 sequences ----------------
    b_src1[2*32 +: 32] = 32'h3;  b_src2[2*32 +: 32] = 32'h5;
    b_src1[0*32 +: 32] = 32'h2;  b_src2[0*32 +: 32] = 32'h3;
    b_src1[1*32 +: 32] = 32'h4;  b_src2[1*32 +: 32] = 32'h5;

    b_step(1, 4'b0000);
    check("b_reset_ready", 32'(b_ready), 32'h0);
    check("b_reset_busy", 32'(b_busy), 32'h0);

    // t0: req2 accepted
    b_step(0, 4'b0100);
    check("b_t0_ready", 32'(b_ready), 32'h4);
    check("b_t0_mul_src1", b_mul_src1, 32'h3);
    check("b_t0_busy", 32'(b_busy), 32'h0);
    // t1, t2: req2 blocked while in flight
    b_step(0, 4'b0100);
    check("b_t1_ready", 32'(b_ready), 32'h0);
    check("b_t1_busy", 32'(b_busy), 32'h1);
    check("b_t1_rsp_valid", 32'(b_rsp_valid), 32'h0);
    b_step(0, 4'b0100);
    check("b_t2_ready", 32'(b_ready), 32'h0);
    check("b_t2_rsp_valid", 32'(b_rsp_valid), 32'h0);
    // t3: completion plus same-cycle re-grant
    b_step(0, 4'b0100);
    check("b_t3_rsp_valid", 32'(b_rsp_valid), 32'h4);
    check("b_t3_rsp_id", 32'(b_rsp_id), 32'h2);
    check("b_t3_rsp_result", b_rsp_result, 32'd15);
    check("b_t3_ready", 32'(b_ready), 32'h4);
    // t4..t6: second op drains
    b_step(0, 4'b0000);
    check("b_t4_busy", 32'(b_busy), 32'h1);
    check("b_t4_rsp_valid", 32'(b_rsp_valid), 32'h0);
    b_step(0, 4'b0000);
    check("b_t5_rsp_valid", 32'(b_rsp_valid), 32'h0);
    b_step(0, 4'b0000);
    check("b_t6_rsp_valid", 32'(b_rsp_valid), 32'h4);
    check("b_t6_rsp_result", b_rsp_result, 32'd15);
    b_step(0, 4'b0000);
    check("b_t7_busy", 32'(b_busy), 32'h0);

    // t8, t9: two ops in flight (rr_ptr is 3, so req0 wins first)
    b_step(0, 4'b0011);
    check("b_t8_ready", 32'(b_ready), 32'h1);
    check("b_t8_mul_src1", b_mul_src1, 32'h2);
    b_step(0, 4'b0011);
    check("b_t9_ready", 32'(b_ready), 32'h2);
    b_step(0, 4'b0011);
    check("b_t10_ready", 32'(b_ready), 32'h0);
    // t11: reset while the first op would complete
    b_step(1, 4'b0011);
    check("b_t11_ready", 32'(b_ready), 32'h0);
    check("b_t11_rsp_valid", 32'(b_rsp_valid), 32'h0);
    // t12: everything discarded
    b_step(0, 4'b0000);
    check("b_t12_busy", 32'(b_busy), 32'h0);
    check("b_t12_ready", 32'(b_ready), 32'h0);
    check("b_t12_rsp_valid", 32'(b_rsp_valid), 32'h0);
    // t13: first post-reset grant goes to the lowest eligible index
    b_step(0, 4'b0110);
    check("b_t13_ready", 32'(b_ready), 32'h2);
    check("b_t13_mul_src1", b_mul_src1, 32'h4);
    check("b_t13_rsp_valid", 32'(b_rsp_valid), 32'h0);
    b_step(0, 4'b0000);
    check("b_t14_rsp_valid", 32'(b_rsp_valid), 32'h0);
    b_step(0, 4'b0000);
    check("b_t15_rsp_valid", 32'(b_rsp_valid), 32'h0);
    b_step(0, 4'b0000);
    check("b_t16_rsp_valid", 32'(b_rsp_valid), 32'h2);
    check("b_t16_rsp_id", 32'(b_rsp_id), 32'h1);
    check("b_t16_rsp_result", b_rsp_result, 32'd20);
    b_step(0, 4'b0000);
    check("b_t17_busy", 32'(b_busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
